ahb_burst_addr_gen: RTL and testbench

//  Parametrised AHB-Lite master address-phase sequencer: accepts one burst command

---
 rtl/ahb_burst_addr_gen.sv | 183 ++++++++++++++++++
 tb/tb_ahb_burst_addr_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen: AHB-Lite master address-phase sequencer, one burst command at a time.
// Define AHB_BUSY_INSERT_EN to let stall_req insert BUSY transfers inside a burst.
module ahb_burst_addr_gen #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [HBURST_WIDTH-1:0] cmd_burst,
    input  logic [2:0]              cmd_size,
    input  logic                    cmd_write,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    stall_req,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic [1:0]              HTRANS,
    output logic [HBURST_WIDTH-1:0] HBURST,
    output logic [2:0]              HSIZE,
    output logic                    HWRITE,
    output logic                    done,
    output logic                    err
);
    localparam int BW = (LEN_WIDTH + 1 > 5) ? LEN_WIDTH + 1 : 5;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ERR} state_t;
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, mask_q, mask_d;
    logic [1:0]              trans_q, trans_d, resume_q, resume_d;
    logic [HBURST_WIDTH-1:0] burst_q, burst_d;
    logic [2:0]              size_q, size_d;
    logic                    write_q, write_d, done_q, done_d, err_q, err_d;
    logic                    ready_q, ready_d, incr_q, incr_d, dph_q, dph_d;
    logic [BW-1:0]           left_q, left_d;
    logic [BW-1:0]           c_beats;
    logic [ADDR_WIDTH-1:0]   c_inc, c_addr, c_last, inc, nxt_addr;
    logic                    c_wrap, c_cross, c_to_incr, c_bad, stall_en, busy_go;
    logic [1:0]              nxt_type;
    assign c_beats = (cmd_burst[2:0] == 3'd0) ? BW'(1) :
                     (cmd_burst[2:0] == 3'd1) ? BW'(cmd_len) + BW'(1) :
                     (cmd_burst[2:1] == 2'd1) ? BW'(4) :
                     (cmd_burst[2:1] == 2'd2) ? BW'(8) : BW'(16);
    assign c_inc     = ADDR_WIDTH'(1) << cmd_size;
    assign c_addr    = cmd_addr & ~(c_inc - ADDR_WIDTH'(1));
    assign c_last    = c_addr + ((ADDR_WIDTH'(c_beats) - ADDR_WIDTH'(1)) << cmd_size);
    assign c_cross   = c_last[ADDR_WIDTH-1:10] != c_addr[ADDR_WIDTH-1:10];
    assign c_wrap    = !cmd_burst[0] && (cmd_burst[2:0] != 3'd0);
    // Undefined-length INCR and fixed INCRn that would cross a 1KB page both run as INCR.
    assign c_to_incr = (cmd_burst[2:0] == 3'd1) || (cmd_burst[0] && cmd_burst[2:1] != 2'd0 && c_cross);
    assign c_bad     = cmd_size > MAX_SIZE;
    // A single mask covers both cases: all-ones for incrementing, boundary-1 for wrapping.
    assign inc       = ADDR_WIDTH'(1) << size_q;
    assign nxt_addr  = (addr_q & ~mask_q) | ((addr_q + inc) & mask_q);
    assign nxt_type  = (incr_q && nxt_addr[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
`ifdef AHB_BUSY_INSERT_EN
    assign stall_en  = stall_req;
`else
    logic unused_stall;
    assign unused_stall = stall_req;
    assign stall_en  = 1'b0;
`endif
    assign busy_go   = stall_en && (left_q > BW'(2) || incr_q);
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        trans_d  = trans_q;
        burst_d  = burst_q;
        size_d   = size_q;
        write_d  = write_q;
        left_d   = left_q;
        mask_d   = mask_q;
        incr_d   = incr_q;
        resume_d = resume_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        dph_d    = HREADY ? trans_q[1] : dph_q;
        case (state_q)
            S_IDLE: begin
                trans_d = T_IDLE;
                if (cmd_valid && ready_q) begin
                    if (c_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        addr_d  = c_addr;
                        burst_d = c_to_incr ? HBURST_WIDTH'(1) : cmd_burst;
                        size_d  = cmd_size;
                        write_d = cmd_write;
                        left_d  = c_beats;
                        mask_d  = c_wrap ? (ADDR_WIDTH'(c_beats) << cmd_size) - ADDR_WIDTH'(1) : '1;
                        incr_d  = c_to_incr;
                        trans_d = T_NONSEQ;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR, S_BURST: begin
                if (!HREADY && HRESP && dph_q) begin
                    trans_d = T_IDLE;
                    state_d = S_ERR;
                end else if (HREADY && trans_q[1]) begin
                    if (left_q == BW'(1)) begin
                        trans_d = T_IDLE;
                        state_d = S_DRAIN;
                    end else begin
                        addr_d   = nxt_addr;
                        left_d   = left_q - BW'(1);
                        trans_d  = busy_go ? T_BUSY : nxt_type;
                        resume_d = nxt_type;
                        state_d  = S_BURST;
                    end
                end else if (HREADY) begin
                    trans_d = stall_en ? T_BUSY : resume_q;
                end
            end
            S_DRAIN: begin
                if (!HREADY && HRESP && dph_q) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                trans_d = T_IDLE;
                if (HREADY) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE) && !done_d;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            trans_q  <= T_IDLE;
            burst_q  <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            left_q   <= '0;
            mask_q   <= '0;
            incr_q   <= 1'b0;
            resume_q <= T_IDLE;
            dph_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            trans_q  <= trans_d;
            burst_q  <= burst_d;
            size_q   <= size_d;
            write_q  <= write_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            left_q   <= left_d;
            mask_q   <= mask_d;
            incr_q   <= incr_d;
            resume_q <= resume_d;
            dph_q    <= dph_d;
        end
    end
    assign cmd_ready = ready_q;
    assign HADDR     = addr_q;
    assign HTRANS    = trans_q;
    assign HBURST    = burst_q;
    assign HSIZE     = size_q;
    assign HWRITE    = write_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// tb_ahb_burst_addr_gen: directed self-checking bench for ahb_burst_addr_gen (32-bit bus).
module tb_ahb_burst_addr_gen;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
    logic        HCLK = 1'b0, HRESETn = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0;
    logic        stall_req = 1'b0, HREADY = 1'b1, HRESP = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_burst = '0, cmd_size = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_ready, HWRITE, done, err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    int          n_chk = 0, n_fail = 0, nb;
    logic [31:0] ea[32];
    logic [1:0]  et[32];
    logic        es[32], eh[32];
    always #5 HCLK = ~HCLK;
    ahb_burst_addr_gen dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_write(cmd_write),
        .cmd_len(cmd_len), .stall_req(stall_req), .HREADY(HREADY), .HRESP(HRESP),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .done(done), .err(err)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask
    task automatic clr();
        for (int i = 0; i < 32; i++) begin
            es[i] = 1'b0;
            eh[i] = 1'b1;
        end
    endtask
    task automatic issue(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                         input logic w, input logic [7:0] l);
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_addr  = a;
        cmd_burst = b;
        cmd_size  = s;
        cmd_write = w;
        cmd_len   = l;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask
    task automatic run_beats(input string name, input int n, input logic [2:0] hb);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.beat%0d.htrans", name, i), HTRANS, et[i]);
            chk($sformatf("%s.beat%0d.haddr", name, i), HADDR, ea[i]);
            chk($sformatf("%s.beat%0d.hburst", name, i), HBURST, hb);
            stall_req = es[i];
            HREADY    = eh[i];
            step();
        end
        stall_req = 1'b0;
        HREADY    = 1'b1;
    endtask
    task automatic finish_burst(input string name);
        chk({name, ".drain_idle"}, HTRANS, IDLE);
        chk({name, ".drain_nodone"}, done, 0);
        step();
        chk({name, ".done"}, done, 1);
        chk({name, ".err"}, err, 0);
        chk({name, ".done_ready_low"}, cmd_ready, 0);
        chk({name, ".done_idle"}, HTRANS, IDLE);
        step();
        chk({name, ".done_pulse"}, done, 0);
        chk({name, ".ready_back"}, cmd_ready, 1);
    endtask
    initial begin
        clr();
        step();
        step();
        chk("rst.htrans", HTRANS, IDLE);
        chk("rst.haddr", HADDR, 0);
        chk("rst.hburst", HBURST, 0);
        chk("rst.hsize", HSIZE, 0);
        chk("rst.hwrite", HWRITE, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.cmd_ready", cmd_ready, 1);
        HRESETn = 1'b1;
        step();
        // INCR4 word write from 0x100
        issue(32'h100, 3'd3, 3'd2, 1'b1, 8'd0);
        chk("incr4.hsize", HSIZE, 2);
        chk("incr4.hwrite", HWRITE, 1);
        chk("incr4.ready_busy", cmd_ready, 0);
        ea[0:3] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        et[0:3] = '{NONSEQ, SEQ, SEQ, SEQ};
        run_beats("incr4", 4, 3'd3);
        finish_burst("incr4");
        // WRAP8 word read from 0x134
        issue(32'h134, 3'd4, 3'd2, 1'b0, 8'd0);
        chk("wrap8.hwrite", HWRITE, 0);
        ea[0:7] = '{32'h134, 32'h138, 32'h13C, 32'h120, 32'h124, 32'h128, 32'h12C, 32'h130};
        et[0:7] = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
        run_beats("wrap8", 8, 3'd4);
        finish_burst("wrap8");
        // Undefined INCR, 4 beats, across the 0x400 page
        issue(32'h3F8, 3'd1, 3'd2, 1'b1, 8'd3);
        ea[0:3] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        et[0:3] = '{NONSEQ, SEQ, NONSEQ, SEQ};
        run_beats("incr_1k", 4, 3'd1);
        finish_burst("incr_1k");
        // INCR16 crossing 1KB is downgraded to INCR
        issue(32'h3F0, 3'd7, 3'd2, 1'b0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            ea[i] = 32'h3F0 + 32'(4 * i);
            et[i] = (i == 0 || i == 4) ? NONSEQ : SEQ;
        end
        run_beats("incr16_1k", 16, 3'd1);
        finish_burst("incr16_1k");
        // HREADY low for 3 cycles while 0x104 is on the bus
        issue(32'h100, 3'd3, 3'd2, 1'b1, 8'd0);
        ea[0:6] = '{32'h100, 32'h104, 32'h104, 32'h104, 32'h104, 32'h108, 32'h10C};
        et[0:6] = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
        eh[1] = 1'b0;
        eh[2] = 1'b0;
        eh[3] = 1'b0;
        run_beats("wait", 7, 3'd3);
        clr();
        finish_burst("wait");
        // ERROR on the second beat of INCR8
        issue(32'h200, 3'd5, 3'd2, 1'b0, 8'd0);
        chk("error.b0", HADDR, 32'h200);
        step();
        chk("error.b1", HADDR, 32'h204);
        step();
        chk("error.b2_addr", HADDR, 32'h208);
        chk("error.b2_trans", HTRANS, SEQ);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        step();
        chk("error.cancel_idle", HTRANS, IDLE);
        chk("error.cancel_nodone", done, 0);
        HREADY = 1'b1;
        step();
        HRESP = 1'b0;
        chk("error.done", done, 1);
        chk("error.err", err, 1);
        chk("error.idle2", HTRANS, IDLE);
        step();
        chk("error.done_pulse", done, 0);
        chk("error.err_pulse", err, 0);
        chk("error.ready", cmd_ready, 1);
        chk("error.no_seq", HTRANS, IDLE);
        // stall_req for 2 cycles after the first beat of INCR4
        issue(32'h100, 3'd3, 3'd2, 1'b1, 8'd0);
`ifdef AHB_BUSY_INSERT_EN
        nb = 6;
        ea[0:5] = '{32'h100, 32'h104, 32'h104, 32'h104, 32'h108, 32'h10C};
        et[0:5] = '{NONSEQ, BUSY, BUSY, SEQ, SEQ, SEQ};
`else
        nb = 4;
        ea[0:3] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        et[0:3] = '{NONSEQ, SEQ, SEQ, SEQ};
`endif
        es[0] = 1'b1;
        es[1] = 1'b1;
        run_beats("busy", nb, 3'd3);
        clr();
        finish_burst("busy");
        // SINGLE halfword at an odd address is aligned down
        issue(32'h123, 3'd0, 3'd1, 1'b0, 8'd0);
        ea[0] = 32'h122;
        et[0] = NONSEQ;
        run_beats("single", 1, 3'd0);
        chk("single.hsize", HSIZE, 1);
        finish_burst("single");
        // WORDX2 on a 32-bit bus is rejected without bus activity
        issue(32'h500, 3'd3, 3'd3, 1'b0, 8'd0);
        chk("badsize.done", done, 1);
        chk("badsize.err", err, 1);
        chk("badsize.no_nonseq", HTRANS, IDLE);
        step();
        chk("badsize.done_pulse", done, 0);
        chk("badsize.still_idle", HTRANS, IDLE);
        chk("badsize.ready", cmd_ready, 1);
        // Reset in the middle of a burst
        issue(32'h100, 3'd3, 3'd2, 1'b1, 8'd0);
        step();
        chk("midrst.pre", HADDR, 32'h104);
        HRESETn = 1'b0;
        step();
        chk("midrst.idle", HTRANS, IDLE);
        chk("midrst.haddr", HADDR, 0);
        chk("midrst.nodone", done, 0);
        HRESETn = 1'b1;
        step();
        chk("midrst.ready", cmd_ready, 1);
        chk("midrst.still_idle", HTRANS, IDLE);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
